// File: rtl/pe_ctrl_pkg.sv
// Shared definitions for the PE group controller.
// Holds the controller state encoding, the legal layer codes, the default
// ifmap fill depths per layer, the default PE pipeline latency, and a
// helper that says whether a layer code can be run.
package pe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WLOAD  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } ctrl_state_e;

  localparam logic [3:0] LAYER_L1 = 4'd1;  // 5-tap
  localparam logic [3:0] LAYER_L3 = 4'd3;  // 3-tap
  localparam logic [3:0] LAYER_L4 = 4'd4;  // stride-2

  localparam int FILL_L1_DEF = 4;
  localparam int FILL_L3_DEF = 2;
  localparam int FILL_L4_DEF = 1;
  localparam int PE_LAT_DEF  = 3;

  function automatic logic layer_legal(input logic [3:0] lyr);
    return (lyr == LAYER_L1) || (lyr == LAYER_L3) || (lyr == LAYER_L4);
  endfunction

endpackage

// File: rtl/valid_delay.sv
// Aligns the groupsum valid flag with the PE datapath.
// A DEPTH-deep shift register carries {calculate_en, window index}; the
// output stage is a register, so out_valid rises exactly DEPTH cycles after
// the enable was high. The index is zeroed on bubbles so out_idx reads 0
// whenever out_valid is low.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   flush            - synchronous clear of every stage (row cancel)
//   in_valid, in_idx - calculate_en and its window index
//   out_valid, out_idx - delayed copies
module valid_delay
  import pe_ctrl_pkg::*;
#(
  parameter int DEPTH = PE_LAT_DEF,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic [DEPTH-1:0] vld_r;
  logic [IDX_W-1:0] idx_r [DEPTH];

  // Shift pipeline for the valid flag and its window index.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_r[i] <= 1'b0;
        idx_r[i] <= '0;
      end
    end else begin
      vld_r[0] <= in_valid;
      idx_r[0] <= in_valid ? in_idx : '0;
      for (int i = 1; i < DEPTH; i++) begin
        vld_r[i] <= vld_r[i-1];
        idx_r[i] <= idx_r[i-1];
      end
    end
  end

  assign out_valid = vld_r[DEPTH-1];
  assign out_idx   = idx_r[DEPTH-1];

endmodule

// File: rtl/pe_group_ctrl.sv
// Controller for one PE group: processes one output row per start.
// Sequence: WLOAD (weight read, then weight_en), STREAM (ifmap reads plus
// calculate_en for each output window), DRAIN (wait for the PE pipeline),
// DONE (one-cycle done pulse). All outputs are registered: the next-cycle
// value of each strobe is decoded from the next state and counters.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start, abort        - row request / row cancel
//   layer, out_cnt      - layer code (1,3,4 legal), windows in the row
//   w_base, if_base     - BRAM base addresses
//   w_rd_en, w_addr     - weight BRAM read
//   if_rd_en, if_addr   - ifmap BRAM read (address wraps modulo 1024)
//   weight_en           - PE weight register load pulse
//   calculate_en        - PE multiply enable
//   out_valid, out_idx  - groupsum valid and window index
//   busy, done, err     - status (done/err are one-cycle pulses)
module pe_group_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int FILL_L1 = FILL_L1_DEF,
  parameter int FILL_L3 = FILL_L3_DEF,
  parameter int FILL_L4 = FILL_L4_DEF,
  parameter int PE_LAT  = PE_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] layer,
  input  logic [7:0] out_cnt,
  input  logic [9:0] w_base,
  input  logic [9:0] if_base,
  output logic       w_rd_en,
  output logic [9:0] w_addr,
  output logic       if_rd_en,
  output logic [9:0] if_addr,
  output logic       weight_en,
  output logic       calculate_en,
  output logic       out_valid,
  output logic [7:0] out_idx,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [8:0] DRAIN_LAST = 9'(PE_LAT - 1);

  ctrl_state_e state_r, state_nx_s;
  // Cycle index within the current state; in STREAM it is also the read count.
  logic [8:0] cyc_r, cyc_nx_s;
  logic [7:0] win_cnt_r, win_nx_s;
  logic [3:0] layer_r;
  logic [7:0] cnt_r;
  logic [9:0] w_base_r, if_base_r;
  logic [7:0] calc_idx_r, calc_idx_nx_s;

  logic       accept_s, abort_s, err_nx_s;
  logic [7:0] fill_s;
  logic [8:0] reads_s, first_calc_s, last_calc_s;
  logic [9:0] w_base_s;
  logic       w_rd_en_nx_s, weight_en_nx_s, if_rd_en_nx_s, calc_nx_s;
  logic       done_nx_s, busy_nx_s;
  logic [9:0] w_addr_nx_s, if_addr_nx_s;

  // Fill depth of the latched layer.
  always_comb begin
    fill_s = 8'd0;
    case (layer_r)
      LAYER_L1: fill_s = 8'(FILL_L1);
      LAYER_L3: fill_s = 8'(FILL_L3);
      LAYER_L4: fill_s = 8'(FILL_L4);
      default:  fill_s = 8'd0;
    endcase
  end

  // Stream shape: reads occupy cycles [0, reads), windows [fill+2, reads+1].
  assign reads_s      = {1'b0, cnt_r} + {1'b0, fill_s};
  assign first_calc_s = {1'b0, fill_s} + 9'd2;
  assign last_calc_s  = reads_s + 9'd1;
  assign abort_s      = abort && (state_r != ST_IDLE);
  assign w_base_s     = accept_s ? w_base : w_base_r;

  // Next state, counters, and decode of next-cycle outputs.
  always_comb begin
    state_nx_s = state_r;
    cyc_nx_s   = cyc_r;
    win_nx_s   = win_cnt_r;
    accept_s   = 1'b0;
    err_nx_s   = 1'b0;

    if (abort_s) begin
      state_nx_s = ST_IDLE;
      cyc_nx_s   = 9'd0;
      win_nx_s   = 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cyc_nx_s = 9'd0;
          win_nx_s = 8'd0;
          if (start && !abort) begin
            if (layer_legal(layer)) begin
              accept_s   = 1'b1;
              state_nx_s = ST_WLOAD;
            end else begin
              err_nx_s = 1'b1;
            end
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_WLOAD: begin
          if (cyc_r == 9'd0) begin
            cyc_nx_s = 9'd1;
          end else begin
            cyc_nx_s   = 9'd0;
            state_nx_s = (cnt_r == 8'd0) ? ST_DONE : ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (cyc_r == last_calc_s) begin
            cyc_nx_s   = 9'd0;
            state_nx_s = ST_DRAIN;
          end else begin
            cyc_nx_s = cyc_r + 9'd1;
          end
        end
        ST_DRAIN: begin
          if (cyc_r == DRAIN_LAST) begin
            cyc_nx_s   = 9'd0;
            state_nx_s = ST_DONE;
          end else begin
            cyc_nx_s = cyc_r + 9'd1;
          end
        end
        ST_DONE: begin
          cyc_nx_s   = 9'd0;
          state_nx_s = ST_IDLE;
        end
        default: begin
          cyc_nx_s   = 9'd0;
          state_nx_s = ST_IDLE;
        end
      endcase
    end

    w_rd_en_nx_s   = (state_nx_s == ST_WLOAD) && (cyc_nx_s == 9'd0);
    weight_en_nx_s = (state_nx_s == ST_WLOAD) && (cyc_nx_s == 9'd1);
    if_rd_en_nx_s  = (state_nx_s == ST_STREAM) && (cyc_nx_s < reads_s);
    calc_nx_s      = (state_nx_s == ST_STREAM) && (cyc_nx_s >= first_calc_s)
                     && (cyc_nx_s <= last_calc_s);
    done_nx_s      = (state_nx_s == ST_DONE);
    busy_nx_s      = (state_nx_s != ST_IDLE);

    if (w_rd_en_nx_s) begin
      w_addr_nx_s = w_base_s;
    end else begin
      w_addr_nx_s = 10'd0;
    end

    // 10-bit add wraps the ifmap address modulo 1024.
    if (if_rd_en_nx_s) begin
      if_addr_nx_s = if_base_r + {1'b0, cyc_nx_s};
    end else begin
      if_addr_nx_s = 10'd0;
    end

    if (calc_nx_s) begin
      calc_idx_nx_s = win_cnt_r;
      win_nx_s      = win_cnt_r + 8'd1;
    end else begin
      calc_idx_nx_s = 8'd0;
    end
  end

  // State, counters, latched row parameters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cyc_r        <= 9'd0;
      win_cnt_r    <= 8'd0;
      layer_r      <= 4'd0;
      cnt_r        <= 8'd0;
      w_base_r     <= 10'd0;
      if_base_r    <= 10'd0;
      calc_idx_r   <= 8'd0;
      w_rd_en      <= 1'b0;
      w_addr       <= 10'd0;
      if_rd_en     <= 1'b0;
      if_addr      <= 10'd0;
      weight_en    <= 1'b0;
      calculate_en <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      cyc_r        <= cyc_nx_s;
      win_cnt_r    <= win_nx_s;
      calc_idx_r   <= calc_idx_nx_s;
      w_rd_en      <= w_rd_en_nx_s;
      w_addr       <= w_addr_nx_s;
      if_rd_en     <= if_rd_en_nx_s;
      if_addr      <= if_addr_nx_s;
      weight_en    <= weight_en_nx_s;
      calculate_en <= calc_nx_s;
      busy         <= busy_nx_s;
      done         <= done_nx_s;
      err          <= err_nx_s;
      if (accept_s) begin
        layer_r   <= layer;
        cnt_r     <= out_cnt;
        w_base_r  <= w_base;
        if_base_r <= if_base;
      end
    end
  end

  valid_delay #(
    .DEPTH (PE_LAT),
    .IDX_W (8)
  ) u_valid_delay (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort_s),
    .in_valid  (calculate_en),
    .in_idx    (calc_idx_r),
    .out_valid (out_valid),
    .out_idx   (out_idx)
  );

endmodule

// File: tb/tb_pe_group_ctrl.sv
// Self-checking bench for pe_group_ctrl (default parameters).
// A timeline model schedules, for every accepted row, the cycle of each
// expected strobe (from start time, fill depth and PE latency) and every
// cycle is compared against it. A table of row requests adds checks of
// read counts, latencies and done timing; a few hand sequences cover abort
// and reset; a random phase finishes the run.
module tb_pe_group_ctrl;

  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [3:0] layer;
  logic [7:0] out_cnt;
  logic [9:0] w_base, if_base;
  logic       w_rd_en, if_rd_en, weight_en, calculate_en, out_valid;
  logic [9:0] w_addr, if_addr;
  logic [7:0] out_idx;
  logic       busy, done, err;

  always #5 clk = ~clk;

  pe_group_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .layer(layer),
    .out_cnt(out_cnt), .w_base(w_base), .if_base(if_base),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .if_rd_en(if_rd_en),
    .if_addr(if_addr), .weight_en(weight_en), .calculate_en(calculate_en),
    .out_valid(out_valid), .out_idx(out_idx), .busy(busy), .done(done),
    .err(err)
  );

  typedef struct {
    bit       busy, w_rd_en, weight_en, if_rd_en, calc, valid, done, err;
    bit [9:0] w_addr, if_addr;
    bit [7:0] idx;
  } exp_t;

  typedef struct {
    int layer, cnt, wb, ib;
    int reads, calcs, calc_off, valid_off, done_off, err_off, wen, wrap;
  } vec_t;

  exp_t exp_a [1024];
  exp_t zero_e;
  vec_t tbl [6];
  int vectors = 0;
  int miscompares = 0;
  int cur = 0;
  int busy_until = -1;

  // per-row observations
  int n_rd, n_calc, n_val, n_wen, n_done, n_err, n_busy;
  int t0, first_calc, first_val, done_cyc, err_cyc, wrap_seen, seen_wa;
  bit prev_rd;
  logic [9:0] prev_ia;

  function automatic int fill_of(input logic [3:0] l);
    case (l)
      4'd1:    return 4;
      4'd3:    return 2;
      4'd4:    return 1;
      default: return -1;
    endcase
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 1024; i++) exp_a[i] = zero_e;
  endtask

  task automatic chk(input string name, input int act, input int want);
    vectors++;
    if (act != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  // Apply the rules for the inputs of cycle cur to the expected timeline.
  task automatic model_cycle();
    int c, f, t, fin;
    c = cur;
    if (rst) begin
      clear_model();
      busy_until = c;
    end else if (abort && c <= busy_until) begin
      clear_model();
      busy_until = c;
    end else if (start && !abort && c > busy_until) begin
      f = fill_of(layer);
      if (f < 0) begin
        exp_a[(c + 1) % 1024].err = 1'b1;
      end else begin
        exp_a[(c + 1) % 1024].w_rd_en = 1'b1;
        exp_a[(c + 1) % 1024].w_addr  = w_base;
        exp_a[(c + 2) % 1024].weight_en = 1'b1;
        t = c + 3;
        if (out_cnt == 8'd0) begin
          fin = c + 3;
        end else begin
          for (int k = 0; k < int'(out_cnt) + f; k++) begin
            exp_a[(t + k) % 1024].if_rd_en = 1'b1;
            exp_a[(t + k) % 1024].if_addr  = 10'((int'(if_base) + k) % 1024);
          end
          for (int j = 0; j < int'(out_cnt); j++) begin
            exp_a[(t + f + 2 + j) % 1024].calc = 1'b1;
            exp_a[(t + f + 2 + j + LAT) % 1024].valid = 1'b1;
            exp_a[(t + f + 2 + j + LAT) % 1024].idx = 8'(j);
          end
          fin = t + f + int'(out_cnt) + LAT + 2;
        end
        exp_a[fin % 1024].done = 1'b1;
        for (int b = c + 1; b <= fin; b++) exp_a[b % 1024].busy = 1'b1;
        busy_until = fin;
      end
    end
  endtask

  task automatic check_cycle();
    exp_t e;
    bit ok;
    e = exp_a[cur % 1024];
    ok = (busy === e.busy) && (w_rd_en === e.w_rd_en) && (weight_en === e.weight_en)
      && (if_rd_en === e.if_rd_en) && (calculate_en === e.calc)
      && (out_valid === e.valid) && (done === e.done) && (err === e.err)
      && (!e.w_rd_en || w_addr === e.w_addr) && (!e.if_rd_en || if_addr === e.if_addr)
      && (!e.valid || out_idx === e.idx);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL cycle %0d: got busy=%b wr=%b wa=%0d we=%b ir=%b ia=%0d ce=%b ov=%b oi=%0d dn=%b er=%b; want busy=%b wr=%b wa=%0d we=%b ir=%b ia=%0d ce=%b ov=%b oi=%0d dn=%b er=%b",
               cur, busy, w_rd_en, w_addr, weight_en, if_rd_en, if_addr, calculate_en,
               out_valid, out_idx, done, err, e.busy, e.w_rd_en, e.w_addr, e.weight_en,
               e.if_rd_en, e.if_addr, e.calc, e.valid, e.idx, e.done, e.err);
    end
    exp_a[cur % 1024] = zero_e;
  endtask

  task automatic clear_stats();
    n_rd = 0; n_calc = 0; n_val = 0; n_wen = 0; n_done = 0; n_err = 0; n_busy = 0;
    t0 = -1; first_calc = -1; first_val = -1; done_cyc = -1; err_cyc = -1;
    wrap_seen = 0; seen_wa = -1; prev_rd = 1'b0; prev_ia = 10'd0;
  endtask

  task automatic record();
    if (if_rd_en) begin
      n_rd++;
      if (t0 < 0) t0 = cur;
      if (prev_rd && prev_ia == 10'd1023 && if_addr == 10'd0) wrap_seen = 1;
    end
    if (calculate_en) begin n_calc++; if (first_calc < 0) first_calc = cur; end
    if (out_valid) begin n_val++; if (first_val < 0) first_val = cur; end
    if (weight_en) n_wen++;
    if (w_rd_en) seen_wa = int'(w_addr);
    if (done) begin n_done++; done_cyc = cur; end
    if (err) begin n_err++; err_cyc = cur; end
    if (busy) n_busy++;
    prev_rd = if_rd_en;
    prev_ia = if_addr;
  endtask

  // One clock: model the current inputs, advance, compare, release pulses.
  task automatic tick();
    model_cycle();
    @(posedge clk);
    #1;
    cur++;
    check_cycle();
    record();
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    int s, budget;
    clear_stats();
    layer = v.layer[3:0]; out_cnt = v.cnt[7:0]; w_base = v.wb[9:0]; if_base = v.ib[9:0];
    start = 1'b1;
    s = cur;
    tick();
    // scramble the row inputs: the latched copies must be used
    layer = 4'd2; out_cnt = 8'($urandom); w_base = 10'($urandom); if_base = 10'($urandom);
    budget = 0;
    while (n_done == 0 && n_err == 0 && budget < 400) begin
      tick();
      budget++;
    end
    chk("timeout", (budget >= 400) ? 1 : 0, 0);
    tick();
    tick();
    chk("reads", n_rd, v.reads);
    chk("calcs", n_calc, v.calcs);
    chk("valids", n_val, v.calcs);
    chk("calc_off", (first_calc >= 0 && t0 >= 0) ? first_calc - t0 : -1, v.calc_off);
    chk("valid_off", (first_val >= 0 && t0 >= 0) ? first_val - t0 : -1, v.valid_off);
    chk("done_off", (done_cyc >= 0) ? done_cyc - s : -1, v.done_off);
    chk("err_off", (err_cyc >= 0) ? err_cyc - s : -1, v.err_off);
    chk("weight_en", n_wen, v.wen);
    chk("wrap", wrap_seen, v.wrap);
    if (v.err_off < 0) chk("w_addr", seen_wa, v.wb);
    else chk("err_busy", n_busy, 0);
  endtask

  initial begin
    int s;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    layer = 4'd0; out_cnt = 8'd0; w_base = 10'd0; if_base = 10'd0;
    clear_model();
    //        layer cnt wb  ib   reads calcs c_off v_off done err wen wrap
    tbl[0] = '{1, 3,  5,  10,   7,  3, 6,  9, 15, -1, 1, 0};
    tbl[1] = '{4, 2,  7,  20,   3,  2, 3,  6, 11, -1, 1, 0};
    tbl[2] = '{2, 5,  0,  0,    0,  0, -1, -1, -1, 1, 0, 0};
    tbl[3] = '{3, 0,  9,  30,   0,  0, -1, -1, 3, -1, 1, 0};
    tbl[4] = '{1, 8,  1,  1020, 12, 8, 6,  9, 20, -1, 1, 1};
    tbl[5] = '{3, 5,  2,  100,  7,  5, 4,  7, 15, -1, 1, 0};

    tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_all_zero", int'(|{w_rd_en, weight_en, if_rd_en, calculate_en,
        out_valid, done, err, w_addr, if_addr, out_idx}), 0);
    tick();

    for (int i = 0; i < 6; i++) run_txn(tbl[i]);

    // abort two cycles into STREAM, then a normal row
    clear_stats();
    layer = 4'd1; out_cnt = 8'd3; if_base = 10'd40; w_base = 10'd3;
    start = 1'b1;
    s = cur;
    tick();
    while (cur < s + 5) tick();
    abort = 1'b1;
    tick();
    chk("abort_busy", int'(busy), 0);
    chk("abort_strobes", int'(|{w_rd_en, weight_en, if_rd_en, calculate_en, out_valid}), 0);
    for (int i = 0; i < 20; i++) tick();
    chk("abort_no_done", n_done, 0);
    run_txn(tbl[0]);

    // abort and start together in IDLE: start is not taken
    layer = 4'd1; out_cnt = 8'd2; start = 1'b1; abort = 1'b1;
    tick();
    chk("abort_over_start", int'(busy), 0);

    // reset during DRAIN
    clear_stats();
    layer = 4'd1; out_cnt = 8'd3; if_base = 10'd10; w_base = 10'd5;
    start = 1'b1;
    s = cur;
    tick();
    while (cur < s + 13) tick();
    chk("in_drain_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    chk("rst_drain_all_zero", int'(|{busy, w_rd_en, weight_en, if_rd_en, calculate_en,
        out_valid, done, err, w_addr, if_addr, out_idx}), 0);
    for (int i = 0; i < 10; i++) tick();
    chk("rst_no_done", n_done, 0);

    // random phase, every cycle checked against the timeline model
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      abort = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 5))
        0, 1:    layer = 4'd1;
        2:       layer = 4'd3;
        3:       layer = 4'd4;
        4:       layer = 4'd2;
        default: layer = 4'($urandom);
      endcase
      out_cnt = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                            : 8'($urandom_range(0, 10));
      w_base  = 10'($urandom);
      if_base = 10'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
